// File: rtl/te_pkg.sv
// Shared types and limits for the timing-engine radio-enable sequencer.
package te_pkg;

  localparam int TE_SYNC_STAGES_MIN = 2;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    PLL_WAIT = 2'd1,
    SETTLE   = 2'd2,
    RX_ON    = 2'd3
  } te_seq_state_e;

endpackage

// File: rtl/te_sync_cell.sv
// Single-bit multi-flop synchroniser; the sole CDC/isolation attach point.
module te_sync_cell
  import te_pkg::*;
#(
  parameter int STAGES = TE_SYNC_STAGES_MIN
) (
  input  logic ck,
  input  logic arst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) ff <= '0;
    else         ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/te_radio_seq.sv
// Resynchronises async levels and sequences radio power-up: enable, settle, then RX.
module te_radio_seq
  import te_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_W    = 8
) (
  input  logic                ck,
  input  logic                arst_n,
  input  logic [NUM_CH-1:0]   async_in,
  input  logic                pll_settled,
  input  logic                rx_req,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic [NUM_CH-1:0]   sync_out,
  output logic                radio_enable,
  output logic                radio_rx_en,
  output logic                pll_lost,
  output logic [1:0]          seq_state
);

  localparam int NB = NUM_CH + 2;

  if (SYNC_STAGES < TE_SYNC_STAGES_MIN) begin : g_bad_stages
    $error("te_radio_seq: SYNC_STAGES must be >= %0d", TE_SYNC_STAGES_MIN);
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $error("te_radio_seq: NUM_CH must be >= 1");
  end

  logic [NB-1:0] raw, syn;
  logic          pll_s, rx_s;

  assign raw = {rx_req, pll_settled, async_in};

  for (genvar i = 0; i < NB; i++) begin : g_sync
    te_sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
      .ck     (ck),
      .arst_n (arst_n),
      .d      (raw[i]),
      .q      (syn[i])
    );
  end

  assign sync_out = syn[NUM_CH-1:0];
  assign pll_s    = syn[NUM_CH];
  assign rx_s     = syn[NUM_CH+1];

  te_seq_state_e       st, st_nxt;
  logic [SETTLE_W-1:0] cnt, cnt_nxt;
  logic                lost_nxt;

  // rx_req drop outranks PLL loss, so a simultaneous drop never pulses pll_lost
  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    lost_nxt = 1'b0;
    case (st)
      OFF: if (rx_s) st_nxt = PLL_WAIT;
      PLL_WAIT: begin
        if (!rx_s) st_nxt = OFF;
        else if (pll_s) begin
          st_nxt  = SETTLE;
          cnt_nxt = settle_cycles;
        end
      end
      SETTLE: begin
        if (!rx_s) st_nxt = OFF;
        else if (!pll_s) begin
          st_nxt   = PLL_WAIT;
          lost_nxt = 1'b1;
        end
        else if (cnt == '0) st_nxt = RX_ON;
        else cnt_nxt = cnt - SETTLE_W'(1);
      end
      RX_ON: begin
        if (!rx_s) st_nxt = OFF;
        else if (!pll_s) begin
          st_nxt   = PLL_WAIT;
          lost_nxt = 1'b1;
        end
      end
      default: st_nxt = OFF;
    endcase
  end

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      st  <= OFF;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Enables decoded from next state so they switch on the same edge as the state
  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      radio_enable <= 1'b0;
      radio_rx_en  <= 1'b0;
      pll_lost     <= 1'b0;
    end else begin
      radio_enable <= (st_nxt == SETTLE) || (st_nxt == RX_ON);
      radio_rx_en  <= (st_nxt == RX_ON);
      pll_lost     <= lost_nxt;
    end
  end

  assign seq_state = st;

endmodule

// File: doc/te_radio_seq.md
# te_radio_seq

Parametrised successor to the timing-engine radio-enable synchroniser stage. It resynchronises NUM_CH asynchronous level inputs plus the PLL-settled and RX-request inputs through a configurable-depth flop chain. A radio power-up sequencer then drives radio_enable and radio_rx_en in order, with a programmable settle delay and PLL-loss detection. It sits in the timing-engine power domain, between the PLL and RF control and the radio datapath enables.

## Interface
- NUM_CH, 2, number of general-purpose async level channels (≥1)
- SYNC_STAGES, 2, synchroniser depth per bit (≥2, elaboration error otherwise)
- SETTLE_W, 8, width of settle-delay counter
- ck  in  1  sole clock
- arst_n  in  1  reset; asynchronous assert, active-low
- async_in  in  NUM_CH  async level inputs
- pll_settled  in  1  async PLL-lock indication
- rx_req  in  1  async RX request from timing engine
- settle_cycles  in  SETTLE_W  quasi-static settle delay, sampled on SETTLE entry
- sync_out  out  NUM_CH  synchronised async_in
- radio_enable  out  1  radio power enable
- radio_rx_en  out  1  receiver enable
- pll_lost  out  1  one-cycle pulse: PLL lost while radio enabled
- seq_state  out  2  current sequencer state (debug)

## Operation
- All outputs reset to 0; seq_state resets to OFF (2'd0). Sync chains reset to 0.
- Each async bit passes through SYNC_STAGES flops. pll_s and rx_req_s are the synced versions. The FSM uses only the synced values.
- FSM states (encoding): OFF=0, PLL_WAIT=1, SETTLE=2, RX_ON=3.
- OFF: both enables 0. rx_req_s=1 -> PLL_WAIT.
- PLL_WAIT: both enables 0.
  - rx_req_s=0 -> OFF.
  - Else pll_s=1 -> SETTLE, load cnt<=settle_cycles.
- SETTLE: radio_enable=1, radio_rx_en=0.
  - rx_req_s=0 -> OFF.
  - Else pll_s=0 -> PLL_WAIT with pll_lost pulse.
  - Else cnt==0 -> RX_ON.
  - Else cnt<=cnt-1.
- RX_ON: both enables 1.
  - rx_req_s=0 -> OFF.
  - Else pll_s=0 -> PLL_WAIT with pll_lost pulse.
- Priority: rx_req_s drop beats pll_s drop. If both fall in the same cycle, go to OFF with no pll_lost.
- settle_cycles changes during SETTLE are ignored. settle_cycles=0 gives one cycle in SETTLE.
- The counter never wraps: it decrements only while nonzero in SETTLE.
- Outputs are flops, updated on the same edge as the state register, and are glitch-free.

## Timing
- async_in edge to sync_out: SYNC_STAGES ck edges after the capturing edge.
- Sync chain (pll_settled and rx_req):
  - Input edge to synced value: SYNC_STAGES edges.
  - The FSM reacts on the following edge, so input edge to output change is SYNC_STAGES+1 edges.
- Settle delay: with SETTLE entered at edge E, radio_rx_en rises at edge E+settle_cycles+1.
- Enable deassertion on rx_req fall:
  - Both enables drop together at SYNC_STAGES+1 edges.
  - No ordered power-down is applied; downstream handles it.
- pll_lost is high exactly one cycle, coincident with radio_enable falling.
- arst_n low mid-sequence:
  - All outputs go to 0 immediately (asynchronously).
  - State goes to OFF and sync chains clear.
  - After release, the sequence restarts from OFF. Re-entry takes at least SYNC_STAGES+1 cycles, even with inputs held high.

## Structure
- te_pkg holds:
  - te_seq_state_e (OFF, PLL_WAIT, SETTLE, RX_ON);
  - localparam TE_SYNC_STAGES_MIN=2.
- Sub-module te_sync_cell: a single-bit, SYNC_STAGES-deep synchroniser with ck/arst_n.
  - Instantiated NUM_CH+2 times via generate.
  - It is the only place where CDC constraints and UPF isolation attach.
- Top level contains the generate loop, the FSM, the settle counter and the output flops.

## Test plan
- Reset then idle: arst_n low then released, all inputs 0 -> all outputs 0, seq_state=0 for 20 cycles.
- Nominal bring-up (SYNC_STAGES=2, settle_cycles=5): rx_req=1, then pll_settled=1 -> seq_state 1, then 2. radio_enable rises 3 edges after pll_settled. radio_rx_en rises 6 edges after that. pll_lost stays 0.
- PLL loss in RX_ON: drop pll_settled -> after 3 edges, seq_state=1, both enables 0, pll_lost one-cycle pulse. Re-raise pll_settled -> settle repeats.
- Simultaneous drop: in RX_ON, drop rx_req and pll_settled on the same edge -> seq_state=0, pll_lost never asserts.
- Boundaries:
  - settle_cycles=0 -> radio_rx_en one edge after radio_enable.
  - settle_cycles=255 -> 256-edge gap.
  - Changing settle_cycles mid-SETTLE does not alter the gap.
- Async reset mid-SETTLE: arst_n pulse -> outputs 0 within the reset assertion. After release with inputs high, radio_enable re-rises SYNC_STAGES+2 edges later. Also run with NUM_CH=4 and SYNC_STAGES=3: sync_out latency 3.
